// File: rtl/ex_mdu_if.sv
// Request/response bundle between the execute stage and the iterative multiply/divide unit.
interface ex_mdu_if #(
    parameter int XLEN      = 32,
    parameter int REGADDR_W = 5
);
    logic                 start_i;
    logic [2:0]           op_i;
    logic [XLEN-1:0]      a_i;
    logic [XLEN-1:0]      b_i;
    logic [REGADDR_W-1:0] wd_i;
    logic                 wreg_i;
    logic                 cancel_i;
    logic                 busy_o;
    logic                 stallreq_o;
    logic                 valid_o;
    logic [XLEN-1:0]      result_o;
    logic [REGADDR_W-1:0] wd_o;
    logic                 wreg_o;

    modport master (
        output start_i, op_i, a_i, b_i, wd_i, wreg_i, cancel_i,
        input  busy_o, stallreq_o, valid_o, result_o, wd_o, wreg_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, wd_i, wreg_i, cancel_i,
        output busy_o, stallreq_o, valid_o, result_o, wd_o, wreg_o
    );
endinterface

// File: rtl/ex_mdu.sv
// Iterative RV32M-style multiply/divide: one bit per cycle on operand magnitudes,
// sign fixed up on the last iteration; divide-by-zero and signed overflow bypass CALC.
module ex_mdu #(
    parameter int XLEN      = 32,
    parameter int REGADDR_W = 5
) (
    input  logic     clk,
    input  logic     rst,
    ex_mdu_if.slave  mdu
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;

    logic [CNT_W-1:0]     cnt;
    logic [2:0]           op_q;
    logic                 neg_q;
    logic [XLEN-1:0]      d_q, hi_q, lo_q;
    logic [XLEN-1:0]      result_q;
    logic [REGADDR_W-1:0] wd_q;
    logic                 wreg_q;

    // operand decode
    logic            is_div, a_signed, b_signed, sa, sb;
    logic [XLEN-1:0] a_mag, b_mag, spec_res;
    logic            div_zero, ovf, special, start_ok, last;

    assign is_div   = mdu.op_i[2];
    assign a_signed = is_div ? ~mdu.op_i[0] : (mdu.op_i[1:0] != 2'b11);
    assign b_signed = is_div ? ~mdu.op_i[0] : ~mdu.op_i[1];
    assign sa       = a_signed & mdu.a_i[XLEN-1];
    assign sb       = b_signed & mdu.b_i[XLEN-1];
    assign a_mag    = sa ? -mdu.a_i : mdu.a_i;
    assign b_mag    = sb ? -mdu.b_i : mdu.b_i;
    assign div_zero = is_div & (mdu.b_i == '0);
    assign ovf      = is_div & ~mdu.op_i[0] & (mdu.b_i == '1) &
                      (mdu.a_i == {1'b1, {(XLEN-1){1'b0}}});
    assign special  = div_zero | ovf;
    assign spec_res = div_zero ? (mdu.op_i[1] ? mdu.a_i : '1)
                               : (mdu.op_i[1] ? '0 : mdu.a_i);
    assign start_ok = (state == IDLE) & mdu.start_i & ~mdu.cancel_i;
    assign last     = (cnt == CNT_W'(XLEN - 1));

    // one iteration; {hi_q, lo_q} is the product or {remainder, quotient}
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic [XLEN-1:0]   hi_nx, lo_nx, div_val;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   fin;

    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, d_q} : '0);
        div_sh   = {hi_q, lo_q[XLEN-1]};
        div_diff = div_sh - {1'b0, d_q};
        if (op_q[2]) begin
            if (!div_diff[XLEN]) begin
                hi_nx = div_diff[XLEN-1:0];
                lo_nx = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_nx = div_sh[XLEN-1:0];
                lo_nx = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_nx = mul_sum[XLEN:1];
            lo_nx = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        prod_s  = neg_q ? -{hi_nx, lo_nx} : {hi_nx, lo_nx};
        div_val = op_q[1] ? hi_nx : lo_nx;
        if (op_q[2])
            fin = neg_q ? -div_val : div_val;
        else if (op_q[1:0] == 2'b00)
            fin = prod_s[XLEN-1:0];
        else
            fin = prod_s[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_ok) state_nx = special ? DONE : CALC;
            CALC:    if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (mdu.cancel_i) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            d_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            wd_q     <= '0;
            wreg_q   <= 1'b0;
        end else if (start_ok) begin
            op_q   <= mdu.op_i;
            // remainder takes the dividend's sign, everything else the xor
            neg_q  <= (is_div & mdu.op_i[1]) ? sa : (sa ^ sb);
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= is_div ? a_mag : b_mag;
            d_q    <= is_div ? b_mag : a_mag;
            wd_q   <= mdu.wd_i;
            wreg_q <= mdu.wreg_i;
            if (special) result_q <= spec_res;
        end else if (state == CALC && !mdu.cancel_i) begin
            hi_q <= hi_nx;
            lo_q <= lo_nx;
            cnt  <= cnt + CNT_W'(1);
            if (last) result_q <= fin;
        end
    end

    assign mdu.busy_o     = (state != IDLE);
    assign mdu.valid_o    = (state == DONE);
    assign mdu.stallreq_o = ~rst & (start_ok | (state == CALC));
    assign mdu.result_o   = result_q;
    assign mdu.wd_o       = wd_q;
    assign mdu.wreg_o     = wreg_q;
endmodule

// File: tb/tb_ex_mdu.sv
// Scoreboard bench for ex_mdu at XLEN=32: expected results queued at start, checked on valid_o.
module tb_ex_mdu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ex_mdu_if #(.XLEN(32), .REGADDR_W(5)) mdu_bus ();
    ex_mdu #(.XLEN(32), .REGADDR_W(5)) u_dut (.clk(clk), .rst(rst), .mdu(mdu_bus));

    typedef struct {
        logic [31:0] res;
        logic [4:0]  wd;
        logic        wreg;
        int          t0;
        int          lat;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    endtask

    function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sbv, ub;
        logic [63:0] p;
        logic ovf;
        sa  = {{32{a[31]}}, a};
        sbv = {{32{b[31]}}, b};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = sa * sbv; return p[31:0]; end
            3'd1: begin p = sa * sbv; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * ub; return p[63:32]; end
            3'd4: if (b == 0) return 32'hFFFF_FFFF; else if (ovf) return a; else return $signed(a) / $signed(b);
            3'd5: if (b == 0) return 32'hFFFF_FFFF; else return a / b;
            3'd6: if (b == 0) return a; else if (ovf) return 32'h0; else return $signed(a) % $signed(b);
            default: if (b == 0) return a; else return a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    always @(negedge clk) begin
        if (!rst && mdu_bus.valid_o) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("result", mdu_bus.result_o, e.res);
                chk("wd", mdu_bus.wd_o, e.wd);
                chk("wreg", mdu_bus.wreg_o, e.wreg);
                chk("latency", cyc - e.t0, e.lat);
            end
        end
    end

    // Entered and left at posedge+1: start sampled at the next edge.
    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wd, input logic wreg);
        mdu_bus.start_i = 1'b1;
        mdu_bus.op_i    = op;
        mdu_bus.a_i     = a;
        mdu_bus.b_i     = b;
        mdu_bus.wd_i    = wd;
        mdu_bus.wreg_i  = wreg;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] wd, input logic wreg, input logic [31:0] want,
                          input bit chk_stall);
        int lat;
        lat = is_special(op, a, b) ? 1 : 33;
        drive(op, a, b, wd, wreg);
        sb.push_back('{want, wd, wreg, cyc, lat});
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            if (chk_stall) chk("stallreq", mdu_bus.stallreq_o, (k < lat) ? 64'd1 : 64'd0);
            @(posedge clk); #1;
            mdu_bus.start_i = 1'b0;
        end
        chk("drained", sb.size(), 0);
        if (sb.size() != 0) sb.delete();
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        mdu_bus.cancel_i = 1'b0;
        drive(3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        // start_i held during reset must not raise stallreq
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", mdu_bus.busy_o, 0);
        chk("rst_valid", mdu_bus.valid_o, 0);
        chk("rst_result", mdu_bus.result_o, 0);
        chk("rst_wd", mdu_bus.wd_o, 0);
        chk("rst_wreg", mdu_bus.wreg_o, 0);
        chk("rst_stall", mdu_bus.stallreq_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mdu_bus.start_i = 1'b0;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 1'b1, 32'hFFFF_FFEB, 1'b1);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4, 1'b1, 32'h4000_0000, 1'b0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1'b0, 32'hFFFF_FFFE, 1'b0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd6, 1'b1, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b1, 32'hFFFF_FFFD, 1'b0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 1'b1, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd5, 32'd100, 32'd7, 5'd9, 1'b1, 32'd14, 1'b0);
        run_op(3'd7, 32'd100, 32'd7, 5'd10, 1'b1, 32'd2, 1'b0);
        run_op(3'd5, 32'd5, 32'd0, 5'd11, 1'b1, 32'hFFFF_FFFF, 1'b1);
        run_op(3'd6, 32'd5, 32'd0, 5'd12, 1'b0, 32'd5, 1'b0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b1, 32'h8000_0000, 1'b0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b1, 32'd0, 1'b0);

        // cancel at CALC cycle 10, then restart immediately
        drive(3'd0, 32'd123, 32'd456, 5'd15, 1'b1);
        @(posedge clk); #1;
        mdu_bus.start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1 mdu_bus.cancel_i = 1'b1;
        @(posedge clk); #1;
        mdu_bus.cancel_i = 1'b0;
        chk("cancel_busy", mdu_bus.busy_o, 0);
        chk("cancel_valid", mdu_bus.valid_o, 0);
        run_op(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd16, 1'b1,
               ref_mdu(3'd1, 32'hDEAD_BEEF, 32'h1234_5678), 1'b0);

        // reset at CALC cycle 5, first start right after release
        drive(3'd4, 32'd1000, 32'd3, 5'd17, 1'b1);
        @(posedge clk); #1;
        mdu_bus.start_i = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_stall", mdu_bus.stallreq_o, 0);
        @(posedge clk); #1;
        chk("midrst_busy", mdu_bus.busy_o, 0);
        chk("midrst_valid", mdu_bus.valid_o, 0);
        chk("midrst_result", mdu_bus.result_o, 0);
        chk("midrst_wd", mdu_bus.wd_o, 0);
        chk("midrst_wreg", mdu_bus.wreg_o, 0);
        rst = 1'b0;
        run_op(3'd7, 32'd1000, 32'd3, 5'd18, 1'b1, 32'd1, 1'b0);

        // start held while busy: only the first request may produce a result
        drive(3'd5, 32'd999, 32'd10, 5'd19, 1'b1);
        sb.push_back('{32'd99, 5'd19, 1'b1, cyc, 33});
        for (int k = 0; k <= 33; k++) begin
            @(posedge clk); #1;
            if (k < 20) drive(3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom), 1'($urandom));
            else mdu_bus.start_i = 1'b0;
        end
        chk("held_drained", sb.size(), 0);
        if (sb.size() != 0) sb.delete();
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(op, a, b, 5'(i), 1'(i), ref_mdu(op, a, b), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ex_mdu.md
EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values are even and 8..64.
REQ-002 Parameter REGADDR_W, default 5, destination register address width.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start_i  input  1  request a new operation; sampled only in IDLE.
REQ-006 op_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 a_i, b_i  input  XLEN each  rs1 and rs2 operands.
REQ-008 wd_i  input  REGADDR_W  destination register; wreg_i  input  1  write enable.
REQ-009 cancel_i  input  1  pipeline flush; aborts any operation in progress.
REQ-010 busy_o  output  1  high in CALC and DONE.
REQ-011 stallreq_o  output  1  pipeline stall request.
REQ-012 valid_o  output  1  one-cycle pulse marking result_o valid.
REQ-013 result_o  output  XLEN  result; wd_o  output  REGADDR_W; wreg_o  output  1; all are latched copies.

Function
REQ-014 FSM states: IDLE, CALC, DONE.
REQ-015 IDLE with start_i=1 and cancel_i=0: latch op, operands, wd_i and wreg_i, then go to CALC; go to DONE instead if a special case applies (REQ-021, REQ-022).
REQ-016 CALC: iterate exactly XLEN cycles, one bit per cycle, using a counter of width clog2(XLEN)+1; after the last iteration go to DONE.
REQ-017 DONE: valid_o=1, result_o/wd_o/wreg_o hold final values for that cycle, then go to IDLE.
REQ-018 Latency: normal ops give valid_o XLEN+1 cycles after the start cycle; special cases give valid_o 1 cycle after the start cycle.
REQ-019 Multiply: shift-add on operand magnitudes into a 2*XLEN product, negated at the end if the operand signs differ.
- MUL: a, b signed; returns low XLEN bits.
- MULH: a, b signed; returns high XLEN bits.
- MULHSU: a signed, b unsigned; returns high XLEN bits.
- MULHU: a, b unsigned; returns high XLEN bits.
REQ-020 Divide: restoring division on magnitudes.
- Signed quotient sign = sign(a) XOR sign(b); signed remainder sign = sign(a).
- DIVU/REMU: operands unsigned.
- DIV/DIVU return the quotient; REM/REMU return the remainder.
REQ-021 Divide by zero (b_i=0):
- DIV/DIVU return all ones.
- REM/REMU return a_i.
REQ-022 Signed overflow (a_i = most negative value, b_i = all ones, op DIV/REM):
- DIV returns a_i.
- REM returns 0.
REQ-023 stallreq_o = (IDLE and start_i and not cancel_i) or CALC; it is low in DONE so the pipeline advances with the result.
REQ-024 start_i while busy_o=1 is ignored; no queuing.
REQ-025 cancel_i=1 in any state forces IDLE on the next edge and suppresses valid_o; cancel_i wins over a simultaneous start_i.
REQ-026 Outputs change only on clock edges; result_o holds its last value while idle.

Reset
REQ-027 rst=1 at a clock edge forces IDLE and clears busy_o, valid_o, result_o, wd_o, wreg_o and the internal counter, including mid-CALC.
REQ-028 stallreq_o is 0 while rst=1.
REQ-029 The first start_i is accepted on the cycle after rst deasserts.

Verification (XLEN=32)
REQ-030 MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB; valid_o exactly 33 cycles after start; stallreq_o high for cycles 0..32.
REQ-031 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-032 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM on the same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
REQ-033 Special cases, each with valid_o 1 cycle after start:
- DIVU 5 / 0 -> 0xFFFFFFFF.
- REM 5 / 0 -> 5.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
- REM on the same operands -> 0.
REQ-034 cancel_i pulsed at CALC cycle 10 -> no valid_o, busy_o=0 next cycle; a start on the following cycle completes correctly.
REQ-035 Other events mid-operation:
- rst asserted at CALC cycle 5 -> all outputs 0 next cycle.
- start_i held during CALC -> exactly one valid_o per accepted start; wd_o/wreg_o match the values latched at start.
